// File: rtl/led_pwm_rgb.sv
// ---------------------------------------------------------------------------
// led_pwm_rgb
//
// Multi-channel PWM LED driver. A prescaler generates PWM ticks. A shared
// WIDTH-bit phase counter advances on each tick. Channel c is lit while
// phase < active_duty[c].
//
// Duty writes land in a shadow register. The shadow is copied into the
// active duty only at a period boundary, or at any time while idle, so a
// period in progress is never cut short or stretched.
//
// Ports
//   i_clk           system clock, everything on the rising edge
//   i_rst           asynchronous, active-low reset
//   i_enable        PWM run enable; low holds the counters at zero and
//                   turns the LEDs off
//   i_load          single-cycle strobe that captures i_duty
//   i_duty          packed duties, channel c at [c*WIDTH +: WIDTH]
//   o_led           registered LED drive; ACTIVE_LOW=1 means 0 lights the LED
//   o_period_start  one-cycle pulse in the first cycle o_led shows phase 0
//   o_pending       shadow holds a duty that is not yet active
//
// Parameters
//   CHANNELS    number of LED channels
//   WIDTH       duty/phase resolution; a period is 2^WIDTH ticks
//   PRESCALE    i_clk cycles per tick, must be >= 1 (1 = tick every cycle)
//   ACTIVE_LOW  output polarity
//
// Full-on is not reachable by design: duty 2^WIDTH-1 lights the LED for
// 2^WIDTH-1 of 2^WIDTH ticks.
// ---------------------------------------------------------------------------
module led_pwm_rgb #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_load,
  input  logic [CHANNELS*WIDTH-1:0] i_duty,
  output logic [CHANNELS-1:0]       o_led,
  output logic                      o_period_start,
  output logic                      o_pending
);

  // A PRESCALE of 1 would give a zero-width counter, so keep at least one bit.
  // In that case the counter is permanently 0, and 0 equals the last count,
  // so there is a tick every cycle.
  localparam int unsigned          PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]      PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]     PHASE_LAST = '1;
  localparam logic [CHANNELS-1:0]  LED_OFF    = {CHANNELS{ACTIVE_LOW}};

  logic [PS_W-1:0]           presc_cnt;
  logic [WIDTH-1:0]          phase;
  logic [CHANNELS*WIDTH-1:0] shadow_duty;
  logic [CHANNELS*WIDTH-1:0] active_duty;

  logic                      tick;
  logic                      boundary;
  logic                      apply_now;
  logic [CHANNELS-1:0]       led_next;

  // -------------------------------------------------------------------------
  // Timing strobes
  // -------------------------------------------------------------------------
  assign tick     = i_enable && (presc_cnt == PS_LAST);
  assign boundary = tick && (phase == PHASE_LAST);

  // Idle counts as a boundary. A duty written while disabled becomes active
  // immediately, so the next enable starts with the latest value.
  assign apply_now = boundary || !i_enable;

  // -------------------------------------------------------------------------
  // Prescaler and phase counter
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every always_ff
  // block sees the pre-edge value of every other register. That keeps the
  // evaluation order of these blocks irrelevant.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      presc_cnt <= '0;
      phase     <= '0;
    end else if (!i_enable) begin
      presc_cnt <= '0;
      phase     <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PS_W'(1);
      if (tick) begin
        phase <= phase + WIDTH'(1);   // wraps 2^WIDTH-1 -> 0 naturally
      end
    end
  end

  // -------------------------------------------------------------------------
  // Duty staging: shadow -> active at a boundary (or while idle)
  // -------------------------------------------------------------------------
  // NOTE: the duty registers are ordinary flops, not a RAM. Resetting them is
  // deliberate: a reset must leave every channel dark, with no stale pending
  // duty waiting to be applied.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shadow_duty <= '0;
      active_duty <= '0;
      o_pending   <= 1'b0;
    end else if (i_load && apply_now) begin
      // The new duty bypasses the shadow. Any older shadow value is dropped.
      shadow_duty <= i_duty;
      active_duty <= i_duty;
      o_pending   <= 1'b0;
    end else if (i_load) begin
      // Last write before the boundary wins.
      shadow_duty <= i_duty;
      o_pending   <= 1'b1;
    end else if (apply_now && o_pending) begin
      active_duty <= shadow_duty;
      o_pending   <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Channel compare
  // -------------------------------------------------------------------------
  // NOTE: led_next gets a full default before the loop. Every path through
  // this always_comb therefore assigns it, and no latch is inferred.
  always_comb begin
    led_next = '0;
    if (i_enable) begin
      for (int c = 0; c < CHANNELS; c++) begin
        led_next[c] = (phase < active_duty[c*WIDTH +: WIDTH]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  // o_led is the compare result one cycle after phase/active_duty.
  // The period start is flagged from the same pre-edge state, so the pulse
  // lines up with the cycle in which o_led first shows phase 0. That is the
  // first cycle after a wrap, or the first enabled cycle after idle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_led          <= LED_OFF;
      o_period_start <= 1'b0;
    end else begin
      o_led          <= led_next ^ LED_OFF;
      o_period_start <= i_enable && (phase == '0) && (presc_cnt == '0);
    end
  end

endmodule
